// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package msp430_fetch_pkg;

  typedef enum logic {
    S_VEC,
    S_RUN
  } fetch_state_t;

  localparam logic [15:0] WORD_STEP            = 16'd2;
  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'hFFFE;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch FIFO: circular buffer of {pc, word} entries with a registered head.
// The head register only changes when a new entry becomes the head, so the
// last delivered word stays visible after the FIFO drains or is flushed.
module fetch_fifo
  import msp430_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  head_q, head_d;

  // Next pointers, occupancy and head; flush wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (count_d != '0) begin
        // The new head may be the entry being written this very edge.
        head_d = (push && (wr_ptr_q == rd_ptr_d)) ? wdata : mem[rd_ptr_d];
      end
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = head_q;
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Program counter and instruction fetch stage in front of the word ROM.
// Optional macro FETCH_ODD_FAULT_EN adds fetch_fault, a one-cycle pulse
// flagging a redirect to an odd address (the redirect still proceeds).
//
// state | meaning
// S_VEC | reading the reset vector; next edge loads pc from rom_out
// S_RUN | sequential fetch into prefetch FIFO, redirects accepted
module instr_fetch
  import msp430_fetch_pkg::*;
#(
  parameter int          DEPTH        = 2,
  parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rom_addr,
  output logic        BW,
  input  logic [15:0] rom_out,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_addr
`ifdef FETCH_ODD_FAULT_EN
  ,output logic       fetch_fault
`endif
);

  fetch_state_t          state_q, state_d;
  logic [15:0]           pc_q, pc_d;
  logic                  push, pop, flush;
  fetch_entry_t          wr_entry, head;
  logic [$clog2(DEPTH):0] fifo_count_unused;
  logic                  fifo_full, fifo_empty;

  // Next state, next pc and FIFO controls.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_VEC: begin
        pc_d    = {rom_out[15:1], 1'b0};
        state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect) begin
          flush = 1'b1;
          pc_d  = {redirect_addr[15:1], 1'b0};
        end else begin
          pop  = instr_valid & instr_ready;
          push = !fifo_full | pop;
          if (push) pc_d = pc_q + WORD_STEP;
        end
      end
      default: state_d = S_VEC;
    endcase
  end

  // State and program counter registers; pc is kept even at all times.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_VEC;
      pc_q    <= {RESET_VECTOR[15:1], 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_ODD_FAULT_EN
  // Flag a redirect whose target had bit 0 set.
  always_ff @(posedge clk) begin
    if (rst) fetch_fault <= 1'b0;
    else     fetch_fault <= (state_q == S_RUN) & redirect & redirect_addr[0];
  end
`else
  logic unused_odd_bit;
  assign unused_odd_bit = redirect_addr[0];
`endif

  assign wr_entry = '{pc: pc_q, word: rom_out};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count_unused),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rom_addr    = pc_q;
  assign BW          = 1'b0;
  assign instr       = head.word;
  assign instr_pc    = head.pc;
  assign instr_valid = !fifo_empty;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a behavioural word ROM.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rom_addr;
  logic        BW;
  logic [15:0] rom_out;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_addr;
`ifdef FETCH_ODD_FAULT_EN
  logic        fetch_fault;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .BW            (BW),
    .rom_out       (rom_out),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr)
`ifdef FETCH_ODD_FAULT_EN
    ,.fetch_fault  (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  // ROM contents: reset vector points at 0x4400, other words are address-derived.
  function automatic logic [15:0] rom_word(input logic [15:0] a);
    if (a == 16'hFFFE) return 16'h4400;
    return a ^ 16'hA5A5;
  endfunction

  assign rom_out = rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_addr = 16'h0000;
    step();
    step();

    // Reset state
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'hFFFE);
    check("rst_bw", 32'(BW), 32'd0);

    // Vector fetch, then stream with ready high
    rst = 1'b0;
    instr_ready = 1'b1;
    step();
    check("vec_addr", 32'(rom_addr), 32'h4400);
    check("vec_valid", 32'(instr_valid), 32'd0);
    step();
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_pc", 32'(instr_pc), 32'h4400);
    check("first_instr", 32'(instr), 32'(rom_word(16'h4400)));
    check("first_addr", 32'(rom_addr), 32'h4402);
    step();
    check("second_pc", 32'(instr_pc), 32'h4402);
    check("second_addr", 32'(rom_addr), 32'h4404);

    // Stall from 0x4400: FIFO fills, pc parks at 0x4404
    rst = 1'b1;
    instr_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_pc", 32'(instr_pc), 32'h4400);
    check("stall_instr", 32'(instr), 32'(rom_word(16'h4400)));
    check("stall_addr", 32'(rom_addr), 32'h4404);

    // Full FIFO drained at 1 word/cycle while refilling
    instr_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("stream_valid", 32'(instr_valid), 32'd1);
      check("stream_pc", 32'(instr_pc), 32'(16'h4400 + 16'(2 * k)));
      check("stream_addr", 32'(rom_addr), 32'(16'h4404 + 16'(2 * k)));
    end

    // Redirect with full FIFO and ready high
    redirect = 1'b1;
    redirect_addr = 16'h5000;
    step();
    redirect = 1'b0;
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_hold_pc", 32'(instr_pc), 32'h4406);
    check("redir_addr", 32'(rom_addr), 32'h5000);
    step();
    check("redir_tgt_valid", 32'(instr_valid), 32'd1);
    check("redir_tgt_pc", 32'(instr_pc), 32'h5000);
    check("redir_tgt_instr", 32'(instr), 32'(rom_word(16'h5000)));

    // Sequential wrap through 0xFFFE
    redirect = 1'b1;
    redirect_addr = 16'hFFFC;
    step();
    redirect = 1'b0;
    check("wrap_addr0", 32'(rom_addr), 32'hFFFC);
    step();
    check("wrap_pc0", 32'(instr_pc), 32'hFFFC);
    step();
    check("wrap_pc1", 32'(instr_pc), 32'hFFFE);
    check("wrap_instr1", 32'(instr), 32'h4400);
    check("wrap_addr1", 32'(rom_addr), 32'h0000);
    step();
    check("wrap_pc2", 32'(instr_pc), 32'h0000);
    check("wrap_instr2", 32'(instr), 32'(rom_word(16'h0000)));
    check("wrap_addr2", 32'(rom_addr), 32'h0002);

    // Odd redirect target
    redirect = 1'b1;
    redirect_addr = 16'h5001;
    step();
    redirect = 1'b0;
    check("odd_addr", 32'(rom_addr), 32'h5000);
`ifdef FETCH_ODD_FAULT_EN
    check("odd_fault_on", 32'(fetch_fault), 32'd1);
`endif
    step();
    check("odd_pc", 32'(instr_pc), 32'h5000);
`ifdef FETCH_ODD_FAULT_EN
    check("odd_fault_off", 32'(fetch_fault), 32'd0);
`endif

    // Reset mid-stream beats a pending redirect; redirect ignored in S_VEC
    rst = 1'b1;
    redirect = 1'b1;
    redirect_addr = 16'h1234;
    step();
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_addr", 32'(rom_addr), 32'hFFFE);
    check("mid_rst_pc", 32'(instr_pc), 32'd0);
    rst = 1'b0;
    step();
    check("vec_ign_redir", 32'(rom_addr), 32'h4400);
    redirect = 1'b0;
    step();
    check("post_rst_pc", 32'(instr_pc), 32'h4400);
    check("post_rst_valid", 32'(instr_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
